// File: rtl/barrel_shifter_pkg.sv
// Shared constants for the barrel shifter slice.
// Optional rotate support is enabled by defining BARREL_SHIFTER_ROTATE_EN.
package barrel_shifter_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/barrel_shifter_stage.sv
// One log-shifter stage: shifts (or rotates) by the fixed distance DIST when enabled.
// The rot_i input exists only when BARREL_SHIFTER_ROTATE_EN is defined.
module barrel_shifter_stage
    import barrel_shifter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic             en_i,
    input  logic             dir_i,
`ifdef BARREL_SHIFTER_ROTATE_EN
    input  logic             rot_i,
`endif
    output logic [WIDTH-1:0] data_o
);

    always_comb begin
        data_o = data_i;
        if (en_i) begin
            if (dir_i == DIR_RIGHT) begin
                data_o = data_i >> DIST;
`ifdef BARREL_SHIFTER_ROTATE_EN
                // Bits leaving the LSB end re-enter at the MSB end.
                if (rot_i) begin
                    data_o = (data_i >> DIST) | (data_i << (WIDTH - DIST));
                end
`endif
            end else begin
                data_o = data_i << DIST;
`ifdef BARREL_SHIFTER_ROTATE_EN
                if (rot_i) begin
                    data_o = (data_i << DIST) | (data_i >> (WIDTH - DIST));
                end
`endif
            end
        end
    end

endmodule

// File: rtl/barrel_shifter_unit.sv
// Logarithmic barrel shifter with a one-cycle registered output and valid bit.
// Defining BARREL_SHIFTER_ROTATE_EN adds the rot port and rotate mode.
module barrel_shifter_unit
    import barrel_shifter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_vld,
    input  logic [WIDTH-1:0]           in,
    input  logic [$clog2(WIDTH)-1:0]   shamt,
    input  logic                       dir,
`ifdef BARREL_SHIFTER_ROTATE_EN
    input  logic                       rot,
`endif
    output logic                       out_vld,
    output logic [WIDTH-1:0]           out
);

    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] stageData [SHW+1];
    logic [WIDTH-1:0] out_d, out_q;
    logic             vld_d, vld_q;

    assign stageData[0] = in;

    // Stage k contributes a shift of 2^k when shamt[k] is set.
    for (genvar k = 0; k < SHW; k++) begin : g_stage
        barrel_shifter_stage #(
            .WIDTH (WIDTH),
            .DIST  (1 << k)
        ) u_stage (
            .data_i (stageData[k]),
            .en_i   (shamt[k]),
            .dir_i  (dir),
`ifdef BARREL_SHIFTER_ROTATE_EN
            .rot_i  (rot),
`endif
            .data_o (stageData[k+1])
        );
    end

    always_comb begin
        vld_d = in_vld;
        out_d = out_q;
        if (in_vld) begin
            out_d = stageData[SHW];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
            vld_q <= 1'b0;
        end else begin
            out_q <= out_d;
            vld_q <= vld_d;
        end
    end

    assign out     = out_q;
    assign out_vld = vld_q;

endmodule

// File: tb/tb_barrel_shifter_unit.sv
// Directed self-checking bench for barrel_shifter_unit (WIDTH = 8).
// Rotate vectors are included when BARREL_SHIFTER_ROTATE_EN is defined.
module tb_barrel_shifter_unit;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         inVld;
    logic [W-1:0] inData;
    logic [2:0]   shamt;
    logic         dir;
    logic         rot;
    logic         outVld;
    logic [W-1:0] outData;

    int passCount  = 0;
    int checkCount = 0;

    barrel_shifter_unit #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (inVld),
        .in      (inData),
        .shamt   (shamt),
        .dir     (dir),
`ifdef BARREL_SHIFTER_ROTATE_EN
        .rot     (rot),
`endif
        .out_vld (outVld),
        .out     (outData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                               input logic [W-1:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Drive one operand on the falling edge, away from the sampling edge.
    task automatic applyStimulus(input logic v, input logic [W-1:0] d,
                                 input logic [2:0] s, input logic dr, input logic r);
        @(negedge clk);
        inVld  = v;
        inData = d;
        shamt  = s;
        dir    = dr;
        rot    = r;
    endtask

    task automatic waitResult();
        @(posedge clk);
        #1;
    endtask

    // Bit-by-bit reference, independent of the stage structure.
    function automatic logic [W-1:0] refShift(input logic [W-1:0] d, input int s,
                                              input logic dr, input logic r);
        logic [W-1:0] res;
        res = '0;
        for (int i = 0; i < W; i++) begin
            int src;
            src = (dr == 1'b0) ? i - s : i + s;
            if (src >= 0 && src < W)
                res[i] = d[src];
            else if (r)
                res[i] = d[(src + W) % W];
        end
        return res;
    endfunction

    task automatic vec(input string tag, input logic [W-1:0] d, input logic [2:0] s,
                       input logic dr, input logic r, input logic [W-1:0] expected);
        applyStimulus(1'b1, d, s, dr, r);
        waitResult();
        checkOutput({tag, "_out"}, outData, expected);
        checkOutput({tag, "_vld"}, {7'b0, outVld}, 8'h01);
    endtask

    initial begin
        rst_n  = 1'b0;
        inVld  = 1'b0;
        inData = '0;
        shamt  = '0;
        dir    = 1'b0;
        rot    = 1'b0;
        #12;
        checkOutput("rst_out", outData, 8'h00);
        checkOutput("rst_vld", {7'b0, outVld}, 8'h00);

        @(negedge clk);
        rst_n = 1'b1;

        vec("left5",  8'b11111111, 3'b101, 1'b0, 1'b0, 8'b11100000);
        vec("left7",  8'b11111111, 3'b111, 1'b0, 1'b0, 8'b10000000);
        vec("right3", 8'b11111111, 3'b011, 1'b1, 1'b0, 8'b00011111);
        vec("right1", 8'b11111111, 3'b001, 1'b1, 1'b0, 8'b01111111);
        vec("idL",    8'hA5,       3'b000, 1'b0, 1'b0, 8'hA5);
        vec("idR",    8'hA5,       3'b000, 1'b1, 1'b0, 8'hA5);

        // Valid low: output holds while the operand keeps changing.
        applyStimulus(1'b0, 8'h3C, 3'b010, 1'b0, 1'b0);
        waitResult();
        checkOutput("hold1_out", outData, 8'hA5);
        checkOutput("hold1_vld", {7'b0, outVld}, 8'h00);
        applyStimulus(1'b0, 8'hFF, 3'b001, 1'b1, 1'b0);
        waitResult();
        checkOutput("hold2_out", outData, 8'hA5);
        checkOutput("hold2_vld", {7'b0, outVld}, 8'h00);

        vec("msbR7",  8'b10000000, 3'b111, 1'b1, 1'b0, 8'b00000001);
        vec("noSext", 8'b10110011, 3'b010, 1'b1, 1'b0, 8'b00101100);

        // Back-to-back sweep: one new operand every cycle.
        for (int dr = 0; dr < 2; dr++) begin
            for (int s = 0; s < W; s++) begin
                vec($sformatf("sweep_d%0d_s%0d", dr, s), 8'b10110011, 3'(s), 1'(dr),
                    1'b0, refShift(8'b10110011, s, 1'(dr), 1'b0));
            end
        end

`ifdef BARREL_SHIFTER_ROTATE_EN
        vec("rotL3", 8'b10010110, 3'd3, 1'b0, 1'b1, 8'b10110100);
        vec("rotR3", 8'b10010110, 3'd3, 1'b1, 1'b1, 8'b11010010);
        vec("rot0",  8'b10010110, 3'd3, 1'b0, 1'b0, 8'b10110000);
        for (int dr = 0; dr < 2; dr++) begin
            for (int s = 0; s < W; s++) begin
                vec($sformatf("rsweep_d%0d_s%0d", dr, s), 8'b11001010, 3'(s), 1'(dr),
                    1'b1, refShift(8'b11001010, s, 1'(dr), 1'b1));
            end
        end
`endif

        // Asynchronous reset mid-stream with a valid operand present.
        vec("preRst", 8'h0F, 3'd2, 1'b0, 1'b0, 8'h3C);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_out", outData, 8'h00);
        checkOutput("arst_vld", {7'b0, outVld}, 8'h00);
        waitResult();
        checkOutput("arstHeld_out", outData, 8'h00);
        checkOutput("arstHeld_vld", {7'b0, outVld}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("rel_out", outData, 8'h00);
        checkOutput("rel_vld", {7'b0, outVld}, 8'h00);
        waitResult();
        checkOutput("postRel_out", outData, 8'h3C);
        checkOutput("postRel_vld", {7'b0, outVld}, 8'h01);

        applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        waitResult();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/barrel_shifter_unit.md
Name: barrel_shifter_unit

Overview:
- Parameterised logarithmic barrel shifter with a registered output, used as a shift primitive in the datapath/ALU.
- Shifts an N-bit operand left or right by 0..N-1 positions. Logical shift (zero fill) by default; optional rotate mode.
- One-cycle latency; a valid bit travels alongside the data.

Parameters:
- WIDTH, 8, operand width. Must be a power of two and at least 2.
- SHW, $clog2(WIDTH) (3 at default), shift-amount width. Derived only; never overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_vld  input  1  input operand/control are valid this cycle
- in  input  WIDTH  operand
- shamt  input  SHW  shift amount, unsigned, 0..WIDTH-1
- dir  input  1  0 = shift left (toward MSB), 1 = shift right (toward LSB)
- rot  input  1  present only with BARREL_SHIFTER_ROTATE_EN; 1 = rotate, 0 = logical
- out_vld  output  1  out holds a valid result
- out  output  WIDTH  shifted result, registered

Behaviour:
- Reset: rst_n low asynchronously forces out = 0 and out_vld = 0. Both hold these values until the first rising clk edge after rst_n deasserts.
- Reset mid-operation discards any in-flight result. No reset value is ever exposed as valid.
- Datapath: combinational, SHW stages. Stage k shifts by 2^k when shamt[k]=1 and passes the value through otherwise. Stage 0 takes in; the last stage drives the output register D input.
- Left logical: out = (in << shamt), truncated to WIDTH bits; vacated LSBs are 0.
- Right logical: out = in >> shamt; vacated MSBs are 0. There is no sign extension.
- shamt = 0: out = in, for both values of dir.
- Latency:
  - On each rising clk edge with rst_n high, out_vld <= in_vld.
  - If in_vld = 1, out <= shift result.
  - If in_vld = 0, out holds its previous value (register is enable-gated).
- No backpressure. A new operand may be accepted every cycle (throughput 1 per cycle).
- All bits are unsigned. The maximum shift is WIDTH-1, so there is no overflow or saturation case.
- Inputs are sampled only at the clock edge; in, shamt and dir may change freely between edges.

Optional Feature:
- Macro BARREL_SHIFTER_ROTATE_EN.
- Defined:
  - Port rot exists.
  - When rot=1, bits shifted out re-enter at the opposite end: left rotate out = {in, in} >> (WIDTH - shamt) truncated; right rotate likewise.
  - When rot=0, behaviour is identical to the macro-undefined build.
- Undefined: port rot is absent and all shifts are logical.

Decomposition:
- Shared package barrel_shifter_pkg:
  - default WIDTH constant
  - direction constants DIR_LEFT=1'b0 and DIR_RIGHT=1'b1
- One natural sub-module: barrel_shifter_stage.
  - Parameters WIDTH and DIST.
  - Inputs: data, en, dir (plus rot when the macro is defined).
  - Output: the data shifted by DIST when en=1, else the data unchanged.
  - The top instantiates SHW stages in a generate loop, followed by the output register.

Test Plan:
- Reset: assert rst_n=0 mid-stream with in_vld=1 -> out=8'h00 and out_vld=0 immediately, without waiting for a clock edge; they stay there until the first edge after release.
- Left logical:
  - in=8'b11111111, shamt=3'b101, dir=0, in_vld=1 -> next cycle out=8'b11100000, out_vld=1.
  - shamt=3'b111 -> out=8'b10000000.
- Right logical:
  - in=8'b11111111, shamt=3'b011, dir=1 -> out=8'b00011111.
  - shamt=3'b001 -> out=8'b01111111.
- Identity and hold:
  - shamt=0 with in=8'hA5, either dir -> out=8'hA5.
  - Then in_vld=0 while in changes -> out stays 8'hA5, out_vld=0.
- Back-to-back: new operands on consecutive cycles -> each result appears exactly one cycle later with no bubbles. Also sweep all 8 shamt values for both dir settings against a reference model.
- Rotate (macro defined):
  - in=8'b10010110, shamt=3, dir=0, rot=1 -> out=8'b10110100.
  - Same input with dir=1 -> out=8'b11010010.
